// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC local network interface.
// A flit carries a one-hot destination location code and an 8-bit payload.
package noc_pkg;

    localparam int FLIT_W = 16;

    typedef logic [7:0] loc_t;

    typedef struct packed {
        loc_t       dest;
        logic [7:0] payload;
    } flit_t;

    // Binary column/row (0..3) to the router's one-hot {X, Y} location code.
    function automatic loc_t coord_to_loc(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] w_x_oh;
        logic [3:0] w_y_oh;
        w_x_oh = 4'b0001 << x;
        w_y_oh = 4'b0001 << y;
        return {w_x_oh, w_y_oh};
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB on each pointer tells full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface between a tile core and its mesh router port.
// Injection is credit flow-controlled; ejection returns one credit per freed slot.
module noc_local_ni
    import noc_pkg::*;
#(
    parameter loc_t LOCATION         = 8'b0001_0001,
    parameter int   TX_DEPTH         = 4,
    parameter int   RX_DEPTH         = 4,
    parameter int   ROUTER_BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [1:0]  tx_dest_x,
    input  logic [1:0]  tx_dest_y,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic [15:0] flit_o,
    output logic        flit_valid_o,
    input  logic        credit_i,
    input  logic [15:0] flit_i,
    input  logic        flit_valid_i,
    output logic        credit_o,
    output logic [2:0]  err_o
);

    localparam int CW = $clog2(ROUTER_BUF_DEPTH + 1);
    localparam logic [CW:0] CRED_MAX = (CW+1)'(ROUTER_BUF_DEPTH);

    flit_t       w_tx_flit;
    logic [FLIT_W-1:0] w_tx_head;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_tx_push;
    logic        w_send;

    logic [CW-1:0] r_credits;
    logic [CW:0]   w_cred_next;
    logic          w_cred_ovf;

    logic [7:0]  w_rx_head;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_rx_pop;
    logic        w_rx_ovf;
    logic        w_misroute;

    logic [15:0] r_flit;
    logic        r_flit_valid;
    logic        r_credit_o;
    logic [2:0]  r_err;

    assign w_tx_flit = '{dest: coord_to_loc(tx_dest_x, tx_dest_y), payload: tx_data};
    assign tx_ready  = !rst && !w_tx_full;
    assign w_tx_push = tx_valid && tx_ready;
    assign w_send    = !w_tx_empty && (r_credits != '0);

    noc_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .din   (w_tx_flit),
        .pop   (w_send),
        .dout  (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    // A send never underflows, so the sum only exceeds the max on a surplus credit.
    assign w_cred_next = {1'b0, r_credits} + {{CW{1'b0}}, credit_i} - {{CW{1'b0}}, w_send};
    assign w_cred_ovf  = (w_cred_next > CRED_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CW'(ROUTER_BUF_DEPTH);
        end else if (!w_cred_ovf) begin
            r_credits <= w_cred_next[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flit       <= '0;
            r_flit_valid <= 1'b0;
        end else begin
            r_flit_valid <= w_send;
            if (w_send) r_flit <= w_tx_head;
        end
    end

    assign w_rx_pop   = rx_valid && rx_ready;
    assign w_rx_ovf   = flit_valid_i && w_rx_full && !w_rx_pop;
    assign w_misroute = flit_valid_i && (flit_i[15:8] != LOCATION);

    noc_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (flit_valid_i),
        .din   (flit_i[7:0]),
        .pop   (w_rx_pop),
        .dout  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    assign rx_valid = !w_rx_empty;
    assign rx_data  = w_rx_empty ? 8'h00 : w_rx_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit_o <= 1'b0;
            r_err      <= '0;
        end else begin
            r_credit_o <= w_rx_pop;
            r_err      <= r_err | {w_misroute, w_rx_ovf, w_cred_ovf};
        end
    end

    assign flit_o       = r_flit;
    assign flit_valid_o = r_flit_valid;
    assign credit_o     = r_credit_o;
    assign err_o        = r_err;

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni with TX/RX scoreboards and a credit_o tracker.
module tb_noc_local_ni;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [1:0]  tx_dest_x = '0;
    logic [1:0]  tx_dest_y = '0;
    logic [7:0]  tx_data = '0;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic [15:0] flit_o;
    logic        flit_valid_o;
    logic        credit_i = 1'b0;
    logic [15:0] flit_i = '0;
    logic        flit_valid_i = 1'b0;
    logic        credit_o;
    logic [2:0]  err_o;

    int n_chk = 0, n_pass = 0, n_flits = 0, n_rx = 0, n_cred = 0;
    logic [15:0] txq[$];
    logic [7:0]  rxq[$];
    logic        prev_pop = 1'b0;

    noc_local_ni dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o), .credit_i(credit_i),
        .flit_i(flit_i), .flit_valid_i(flit_valid_i),
        .credit_o(credit_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_flit(input logic [1:0] x, input logic [1:0] y,
                                             input logic [7:0] d);
        return {4'b0001 << x, 4'b0001 << y, d};
    endfunction

    // Present one request for the current cycle; scoreboard it if it will be taken.
    task automatic req(input logic [1:0] x, input logic [1:0] y, input logic [7:0] d,
                       output bit accepted);
        tx_valid  = 1'b1;
        tx_dest_x = x;
        tx_dest_y = y;
        tx_data   = d;
        accepted  = (tx_ready === 1'b1);
        if (accepted) txq.push_back(exp_flit(x, y, d));
    endtask

    task automatic inject(input logic [15:0] f);
        flit_valid_i = 1'b1;
        flit_i       = f;
        if (rxq.size() < 4 || (rx_ready && rxq.size() > 0)) rxq.push_back(f[7:0]);
    endtask

    task automatic credit_pulse();
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && flit_valid_o === 1'b1) begin
            n_flits++;
            if (txq.size() == 0) check("tx_unexpected", flit_valid_o, 0);
            else check("tx_flit", flit_o, txq.pop_front());
        end
        if (!rst && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            n_rx++;
            if (rxq.size() == 0) check("rx_unexpected", rx_valid, 0);
            else check("rx_data", rx_data, rxq.pop_front());
        end
        if (prev_pop || credit_o === 1'b1) check("credit_o", credit_o, prev_pop);
        if (credit_o === 1'b1) n_cred++;
        prev_pop = !rst && rx_valid === 1'b1 && rx_ready === 1'b1;
    end

    initial begin
        bit acc;
        int n_acc;
        int base;

        // Reset values
        tick(); tick();
        @(negedge clk);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_flit_valid", flit_valid_o, 0);
        check("rst_flit_o", flit_o, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_credit_o", credit_o, 0);
        check("rst_err", err_o, 0);
        check("rst_credits", dut.r_credits, 4);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tx_ready", tx_ready, 1);

        // Single send: handshake in cycle N, flit visible in N+2
        tick();
        req(2'd3, 2'd0, 8'hA5, acc);
        check("single_accept", acc, 1);
        tick();
        tx_valid = 1'b0;
        @(negedge clk);
        check("single_n1_valid", flit_valid_o, 0);
        tick();
        @(negedge clk);
        check("single_n2_valid", flit_valid_o, 1);
        check("single_n2_flit", flit_o, 16'h81A5);
        check("single_credits", dut.r_credits, 3);
        tick();
        credit_pulse();
        @(negedge clk);
        check("credit_restore", dut.r_credits, 4);

        // Credit exhaustion
        tick();
        base  = n_flits;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            req(2'(i), 2'(i + 1), 8'(8'h40 + i), acc);
            if (acc) n_acc++;
            tick();
        end
        tx_valid = 1'b0;
        check("exh_accepted", n_acc, 8);
        tick(); tick(); tick();
        check("exh_sent", n_flits - base, 4);
        check("exh_credits", dut.r_credits, 0);
        check("exh_tx_ready", tx_ready, 0);

        credit_pulse();
        tick();
        @(negedge clk);
        check("resume_valid", flit_valid_o, 1);
        check("resume_credits", dut.r_credits, 0);
        tick();
        check("resume_sent", n_flits - base, 5);

        // Send and credit_i together at credits=1
        credit_i = 1'b1;
        tick();
        tick();
        credit_i = 1'b0;
        @(negedge clk);
        check("simul_credits", dut.r_credits, 1);
        check("simul_valid", flit_valid_o, 1);
        tick();
        @(negedge clk);
        check("simul_credits_after", dut.r_credits, 0);
        tick();
        check("simul_sent", n_flits - base, 7);

        for (int i = 0; i < 5; i++) begin
            credit_pulse();
            tick();
        end
        tick();
        check("drain_credits", dut.r_credits, 4);
        check("drain_sent", n_flits - base, 8);
        check("drain_txq_empty", txq.size(), 0);

        // Credit overflow
        credit_pulse();
        @(negedge clk);
        check("ovf_err", err_o, 3'b001);
        check("ovf_credits", dut.r_credits, 4);

        // Ejection with the core stalled, then drained
        tick();
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inject({8'h11, 8'(8'h10 + i)});
            tick();
        end
        flit_valid_i = 1'b0;
        @(negedge clk);
        check("ej_rx_valid", rx_valid, 1);
        check("ej_err", err_o, 3'b011);
        check("ej_head", rx_data, 8'h10);
        tick();
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("ej_delivered", n_rx, 4);
        check("ej_credits_out", n_cred, 4);
        check("ej_rx_empty", rx_valid, 0);

        // Misrouted flit is flagged but still delivered
        inject(16'h2233);
        tick();
        flit_valid_i = 1'b0;
        @(negedge clk);
        check("mis_err", err_o, 3'b111);
        check("mis_rx_valid", rx_valid, 1);
        check("mis_rx_data", rx_data, 8'h33);
        tick(); tick(); tick();
        check("mis_delivered", n_rx, 5);
        check("mis_credits_out", n_cred, 5);

        // Reset in the middle of traffic
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(2'd1, 2'd1, 8'(8'hC0 + i), acc);
            inject({8'h11, 8'(8'h70 + i)});
            tick();
        end
        rst          = 1'b1;
        tx_valid     = 1'b0;
        flit_valid_i = 1'b0;
        txq.delete();
        rxq.delete();
        tick();
        @(negedge clk);
        check("mrst_flit_valid", flit_valid_o, 0);
        check("mrst_flit_o", flit_o, 0);
        check("mrst_rx_valid", rx_valid, 0);
        check("mrst_rx_data", rx_data, 0);
        check("mrst_credit_o", credit_o, 0);
        check("mrst_err", err_o, 0);
        check("mrst_tx_ready", tx_ready, 0);
        check("mrst_credits", dut.r_credits, 4);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_after_tx_ready", tx_ready, 1);
        check("mrst_after_rx_valid", rx_valid, 0);
        tick();
        base = n_flits;
        req(2'd0, 2'd3, 8'h5A, acc);
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_sent", n_flits - base, 1);
        check("post_rst_txq_empty", txq.size(), 0);
        check("post_rst_credits", dut.r_credits, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
